fnd_scan_driver: RTL and testbench



---
 rtl/fnd_pkg.sv | 11 +
 rtl/fnd_seg_lut.sv | 27 ++
 rtl/fnd_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_fnd_scan_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared display-code definitions for the FND scan driver and its segment decoder.
package fnd_pkg;

    typedef logic [3:0] code_t;

    localparam code_t CODE_MINUS = 4'd10;
    localparam code_t CODE_BLANK = 4'd11;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/fnd_seg_lut.sv
// Display code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module fnd_seg_lut
    import fnd_pkg::*;
(
    input  code_t       code_i,
    output logic [6:0]  seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:       seg_o = 7'b1000000;
            4'd1:       seg_o = 7'b1111001;
            4'd2:       seg_o = 7'b0100100;
            4'd3:       seg_o = 7'b0110000;
            4'd4:       seg_o = 7'b0011001;
            4'd5:       seg_o = 7'b0010010;
            4'd6:       seg_o = 7'b0000010;
            4'd7:       seg_o = 7'b1011000;
            4'd8:       seg_o = 7'b0000000;
            4'd9:       seg_o = 7'b0010000;
            CODE_MINUS: seg_o = 7'b0111111;
            default:    seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with guard blanking between digits
// and a double-buffered display image that only swaps at frame boundaries.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int DIV           = 50000,
    parameter int GUARD         = 2,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0]       CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0]       GUARD_CNT = CW'(GUARD);
    localparam logic [IW-1:0]       IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   pending_q, pending_d;

    code_t                  shadowCode_q [N_DIGITS];
    code_t                  shadowCode_d [N_DIGITS];
    logic [N_DIGITS-1:0]    shadowDp_q, shadowDp_d;
    logic [N_DIGITS-1:0]    shadowMask_q, shadowMask_d;

    code_t                  activeCode_q [N_DIGITS];
    code_t                  activeCode_d [N_DIGITS];
    logic [N_DIGITS-1:0]    activeDp_q, activeDp_d;
    logic [N_DIGITS-1:0]    activeMask_q, activeMask_d;

    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [N_DIGITS-1:0]    an_q, an_d;
    logic                   frameDone_q, frameDone_d;

    logic                   tick;
    logic                   wrap;
    code_t                  loadCode [N_DIGITS];
    logic [N_DIGITS-1:0]    loadMask;
    logic                   zeroRun;
    code_t                  curCode;
    logic                   curSuppress;
    logic                   curDp;
    logic [6:0]             lutSeg;
    logic [N_DIGITS-1:0]    anHot;

    assign tick = (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    // A digit is blanked only while every more significant digit, itself included, is zero.
    always_comb begin
        loadMask = '0;
        zeroRun  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            loadCode[i] = digits[4*i +: 4];
        end
        if (lz_en) begin
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                zeroRun     = zeroRun && (loadCode[i] == 4'd0);
                loadMask[i] = zeroRun;
            end
        end
    end

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        shadowCode_d = shadowCode_q;
        shadowDp_d   = shadowDp_q;
        shadowMask_d = shadowMask_q;
        activeCode_d = activeCode_q;
        activeDp_d   = activeDp_q;
        activeMask_d = activeMask_q;
        pending_d    = pending_q;
        frameDone_d  = wrap;

        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        // The swap uses the shadow contents from before this edge, so a load landing on
        // the boundary tick stays pending for the next frame.
        if (wrap && pending_q) begin
            activeCode_d = shadowCode_q;
            activeDp_d   = shadowDp_q;
            activeMask_d = shadowMask_q;
            pending_d    = 1'b0;
        end

        if (load) begin
            shadowCode_d = loadCode;
            shadowDp_d   = dp_in;
            shadowMask_d = loadMask;
            pending_d    = 1'b1;
        end
    end

    assign curCode     = activeCode_q[idx_q];
    assign curSuppress = activeMask_q[idx_q];
    assign curDp       = activeDp_q[idx_q];

    fnd_seg_lut u_seg_lut (
        .code_i (curCode),
        .seg_o  (lutSeg)
    );

    always_comb begin
        anHot = N_DIGITS'(1) << idx_q;
        seg_d = curSuppress ? SEG_OFF : lutSeg;
        dp_d  = curSuppress | ~curDp;
        if (cnt_q < GUARD_CNT) begin
            an_d = AN_OFF;
        end else begin
            an_d = (AN_ACTIVE_LOW != 0) ? ~anHot : anHot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            shadowCode_q <= '{default: CODE_BLANK};
            shadowDp_q   <= '0;
            shadowMask_q <= '0;
            activeCode_q <= '{default: CODE_BLANK};
            activeDp_q   <= '0;
            activeMask_q <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= AN_OFF;
            frameDone_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadowCode_q <= shadowCode_d;
            shadowDp_q   <= shadowDp_d;
            shadowMask_q <= shadowMask_d;
            activeCode_q <= activeCode_d;
            activeDp_q   <= activeDp_d;
            activeMask_q <= activeMask_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frameDone_q  <= frameDone_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: display vectors loaded at frame starts, expected slot
// images queued on load and compared as each digit slot becomes visible.
module tb_fnd_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpIn;
        logic        lz;
        logic [27:0] segs;
        logic [3:0]  dpN;
    } vec_t;

    slot_t sbQ[$];
    vec_t  vecs[6];
    vec_t  midVec;
    vec_t  blankVec;

    fnd_scan_driver #(
        .N_DIGITS      (4),
        .DIV           (4),
        .GUARD         (1),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic slot_t expSlot(vec_t v, int s);
        slot_t r;
        logic [3:0] one;
        one   = 4'b0001;
        r.an  = ~(one << s);
        r.seg = v.segs[7*s +: 7];
        r.dp  = v.dpN[s];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns at the falling edge where frame_done is seen high.
    task automatic waitFrame();
        logic found;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_done_timeout actual=0 required=1");
        end
    endtask

    task automatic pushVec(input vec_t v);
        for (int s = 0; s < 4; s++) sbQ.push_back(expSlot(v, s));
    endtask

    task automatic checkSlot(input string tag);
        slot_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_queue_empty actual=0 required=1", tag);
        end else begin
            e = sbQ.pop_front();
            check({tag, "_an"}, 32'(an), 32'(e.an));
            check({tag, "_seg"}, 32'(seg), 32'(e.seg));
            check({tag, "_dp"}, 32'(dp), 32'(e.dp));
        end
    endtask

    // Load at the start of a frame so the image goes live at the following boundary.
    task automatic applyStimulus(input vec_t v);
        waitFrame();
        digits = v.digits;
        dp_in  = v.dpIn;
        lz_en  = v.lz;
        load   = 1'b1;
        pushVec(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    // From the frame_done sample, slot s is visible two cycles in, then every four.
    task automatic checkOutput(input string tag);
        waitFrame();
        repeat (2) @(posedge clk);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (4) @(posedge clk);
            @(negedge clk);
            checkSlot($sformatf("%s_slot%0d", tag, s));
        end
    endtask

    initial begin
        int fdCount;
        int offCount;
        int firstFd;
        int lastFd;
        slot_t e;

        vecs[0] = '{16'h1234, 4'b0100, 1'b0,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1011000, 7'b1000000}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b1111, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1110};
        vecs[3] = '{16'hA005, 4'b0000, 1'b1,
                    {7'b0111111, 7'b1000000, 7'b1000000, 7'b0010010}, 4'b1111};
        vecs[4] = '{16'hBF89, 4'b1000, 1'b0,
                    {7'b1111111, 7'b1111111, 7'b0000000, 7'b0010000}, 4'b0111};
        vecs[5] = '{16'h0607, 4'b0000, 1'b1,
                    {7'b1111111, 7'b0000010, 7'b1000000, 7'b1011000}, 4'b1111};
        midVec   = '{16'h8888, 4'b0010, 1'b0,
                     {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b1101};
        blankVec = '{16'hBBBB, 4'b0000, 1'b0,
                     {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1111};

        rst    = 1'b1;
        digits = '0;
        dp_in  = '0;
        lz_en  = 1'b0;
        load   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_an", 32'(an), 32'hF);
        check("reset_fd", 32'(frame_done), 32'h0);

        // Scan cadence: one guard cycle per slot, one frame_done per 16 cycles.
        rst      = 1'b0;
        fdCount  = 0;
        offCount = 0;
        firstFd  = -1;
        lastFd   = -1;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (an == 4'hF) offCount++;
            if (frame_done) begin
                fdCount++;
                if (firstFd < 0) firstFd = c;
                lastFd = c;
            end
        end
        check("fd_first_cycle", 32'(firstFd), 32'd16);
        check("fd_last_cycle", 32'(lastFd), 32'd48);
        check("fd_pulse_count", 32'(fdCount), 32'd3);
        check("guard_cycles", 32'(offCount), 32'd12);

        $display("[TB] table vectors");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v]);
            checkOutput($sformatf("vec%0d", v));
        end

        // Load while digit 1 is showing: the rest of this frame keeps the old image.
        $display("[TB] mid-frame load");
        waitFrame();
        repeat (4) @(posedge clk);
        @(negedge clk);
        digits = midVec.digits;
        dp_in  = midVec.dpIn;
        lz_en  = midVec.lz;
        load   = 1'b1;
        sbQ.push_back(expSlot(vecs[5], 2));
        sbQ.push_back(expSlot(vecs[5], 3));
        pushVec(midVec);
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkSlot("mid_old_slot2");
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkSlot("mid_old_slot3");
        checkOutput("mid_new");

        // Reset at idx=2, cnt=2 with a load still pending.
        $display("[TB] reset mid-scan");
        waitFrame();
        digits = 16'h3333;
        dp_in  = 4'b1111;
        lz_en  = 1'b0;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        e = expSlot(midVec, 2);
        check("pre_reset_an", 32'(an), 32'(e.an));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 32'h1);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_fd", 32'(frame_done), 32'h0);
        pushVec(blankVec);
        checkOutput("post_reset");

        check("queue_drained", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
